// File: rtl/bp_io_lce_req_arb.sv
// bp_io_lce_req_arb
//   Shares one I/O LCE request/command channel pair among num_req_p Bedrock
//   burst requesters. Request bursts are granted round-robin and the grant is
//   held until the last beat. Outstanding transactions are limited to
//   max_outstanding_p. Returning command bursts are steered to the requester
//   that issued the matching request, using an in-order tag FIFO.
//
// Ports
//   clk_i, reset_n_i          : clock, synchronous active-low reset
//   req_*_i / req_ready_and_o : per-requester request bursts (flattened)
//   lce_req_*                 : muxed request stream toward the LCE
//   lce_cmd_*                 : command stream returning from the LCE
//   cmd_*_o / cmd_ready_and_i : command stream broadcast; cmd_v_o is one-hot
//   outstanding_o             : credits currently in use
//   unexpected_cmd_o          : sticky flag, a command arrived with no tag
module bp_io_lce_req_arb #(
    parameter int num_req_p         = 2,
    parameter int header_width_p    = 64,
    parameter int data_width_p      = 64,
    parameter int max_outstanding_p = 4
) (
    input  logic                                      clk_i,
    input  logic                                      reset_n_i,

    input  logic [num_req_p*header_width_p-1:0]       req_header_i,
    input  logic [num_req_p*data_width_p-1:0]         req_data_i,
    input  logic [num_req_p-1:0]                      req_v_i,
    input  logic [num_req_p-1:0]                      req_last_i,
    output logic [num_req_p-1:0]                      req_ready_and_o,

    output logic [header_width_p-1:0]                 lce_req_header_o,
    output logic [data_width_p-1:0]                   lce_req_data_o,
    output logic                                      lce_req_v_o,
    output logic                                      lce_req_last_o,
    input  logic                                      lce_req_ready_and_i,

    input  logic [header_width_p-1:0]                 lce_cmd_header_i,
    input  logic [data_width_p-1:0]                   lce_cmd_data_i,
    input  logic                                      lce_cmd_v_i,
    input  logic                                      lce_cmd_last_i,
    output logic                                      lce_cmd_ready_and_o,

    output logic [header_width_p-1:0]                 cmd_header_o,
    output logic [data_width_p-1:0]                   cmd_data_o,
    output logic                                      cmd_last_o,
    output logic [num_req_p-1:0]                      cmd_v_o,
    input  logic [num_req_p-1:0]                      cmd_ready_and_i,

    output logic [$clog2(max_outstanding_p+1)-1:0]    outstanding_o,
    output logic                                      unexpected_cmd_o
);

    localparam int unsigned num_lp   = num_req_p;
    localparam int          idx_w_lp = $clog2(num_req_p);
    localparam int          cnt_w_lp = $clog2(max_outstanding_p + 1);
    localparam int          ptr_w_lp = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;

    typedef enum logic {
        e_idle,
        e_lock
    } state_e;

    state_e                state_q, state_d;
    logic [idx_w_lp-1:0]   rr_ptr_q, rr_ptr_d;
    logic [idx_w_lp-1:0]   lock_idx_q, lock_idx_d;
    logic [cnt_w_lp-1:0]   count_q, count_d;
    logic [ptr_w_lp-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ptr_w_lp-1:0]   rd_ptr_q, rd_ptr_d;
    logic                  unexpected_q, unexpected_d;
    logic [idx_w_lp-1:0]   tag_mem_q [max_outstanding_p];

    logic                  fifo_empty, fifo_full, credit_ok;
    logic                  grant_v;
    logic [idx_w_lp-1:0]   grant_idx;
    logic [idx_w_lp-1:0]   cand_idx;
    int unsigned           cand;
    logic [idx_w_lp-1:0]   head_idx;
    logic                  push, pop, req_hs;

    function automatic logic [idx_w_lp-1:0] idx_inc(input logic [idx_w_lp-1:0] i);
        return (i == idx_w_lp'(num_lp - 1)) ? '0 : i + idx_w_lp'(1);
    endfunction

    function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(max_outstanding_p - 1)) ? '0 : p + ptr_w_lp'(1);
    endfunction

    // Occupancy of the tag FIFO equals the number of credits in use, since
    // every push takes a credit and every pop returns one.
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == cnt_w_lp'(max_outstanding_p));
    assign credit_ok  = (count_q <  cnt_w_lp'(max_outstanding_p));
    assign head_idx   = tag_mem_q[rd_ptr_q];

    // Grant selection: a locked burst keeps its requester regardless of
    // credits; otherwise search round-robin starting at rr_ptr.
    always_comb begin
        grant_v   = 1'b0;
        grant_idx = '0;
        cand      = 0;
        cand_idx  = '0;
        if (state_q == e_lock) begin
            grant_idx = lock_idx_q;
            grant_v   = req_v_i[lock_idx_q];
        end else if (credit_ok && !fifo_full) begin
            for (int unsigned k = 0; k < num_lp; k++) begin
                cand = 32'(rr_ptr_q) + k;
                if (cand >= num_lp) cand = cand - num_lp;
                cand_idx = idx_w_lp'(cand);
                if (!grant_v && req_v_i[cand_idx]) begin
                    grant_v   = 1'b1;
                    grant_idx = cand_idx;
                end
            end
        end
    end

    // Request mux
    always_comb begin
        lce_req_header_o = '0;
        lce_req_data_o   = '0;
        lce_req_last_o   = 1'b0;
        for (int unsigned i = 0; i < num_lp; i++) begin
            if (grant_idx == idx_w_lp'(i)) begin
                lce_req_header_o = req_header_i[i*header_width_p +: header_width_p];
                lce_req_data_o   = req_data_i[i*data_width_p +: data_width_p];
                lce_req_last_o   = req_last_i[i];
            end
        end
    end

    always_comb begin
        req_ready_and_o = '0;
        if (reset_n_i && grant_v) req_ready_and_o[grant_idx] = lce_req_ready_and_i;
    end

    assign lce_req_v_o = reset_n_i & grant_v;

    // Response steering toward the requester at the FIFO head
    always_comb begin
        cmd_v_o = '0;
        if (reset_n_i && !fifo_empty) cmd_v_o[head_idx] = lce_cmd_v_i;
    end

    assign lce_cmd_ready_and_o = reset_n_i & ~fifo_empty & cmd_ready_and_i[head_idx];
    assign cmd_header_o        = lce_cmd_header_i;
    assign cmd_data_o          = lce_cmd_data_i;
    assign cmd_last_o          = lce_cmd_last_i;

    assign outstanding_o    = reset_n_i ? count_q : '0;
    assign unexpected_cmd_o = reset_n_i & unexpected_q;

    assign req_hs = lce_req_v_o & lce_req_ready_and_i;
    assign push   = req_hs & (state_q == e_idle);
    assign pop    = lce_cmd_v_i & lce_cmd_ready_and_o & lce_cmd_last_i;

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        lock_idx_d   = lock_idx_q;
        count_d      = count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        unexpected_d = unexpected_q | (lce_cmd_v_i & fifo_empty);

        if (req_hs) begin
            if (state_q == e_idle) begin
                if (lce_req_last_o) begin
                    rr_ptr_d = idx_inc(grant_idx);
                end else begin
                    state_d    = e_lock;
                    lock_idx_d = grant_idx;
                end
            end else if (lce_req_last_o) begin
                state_d  = e_idle;
                rr_ptr_d = idx_inc(lock_idx_q);
            end
        end

        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);

        case ({push, pop})
            2'b10:   count_d = count_q + cnt_w_lp'(1);
            2'b01:   count_d = count_q - cnt_w_lp'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_q      <= e_idle;
            rr_ptr_q     <= '0;
            lock_idx_q   <= '0;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            unexpected_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            lock_idx_q   <= lock_idx_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            unexpected_q <= unexpected_d;
        end
    end

    // Tag storage needs no reset: entries are only read when count_q > 0.
    always_ff @(posedge clk_i) begin
        if (push) tag_mem_q[wr_ptr_q] <= grant_idx;
    end

endmodule

// File: tb/tb_bp_io_lce_req_arb.sv
module tb_bp_io_lce_req_arb;

    localparam int N    = 2;
    localparam int HW   = 16;
    localparam int DW   = 16;
    localparam int MAXO = 4;
    localparam int CW   = $clog2(MAXO + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [N*HW-1:0]   req_header;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_v, req_last, req_ready_and_o;
    logic [HW-1:0]     lce_req_header_o;
    logic [DW-1:0]     lce_req_data_o;
    logic              lce_req_v_o, lce_req_last_o, lce_req_ready;
    logic [HW-1:0]     lce_cmd_header;
    logic [DW-1:0]     lce_cmd_data;
    logic              lce_cmd_v, lce_cmd_last, lce_cmd_ready_and_o;
    logic [HW-1:0]     cmd_header_o;
    logic [DW-1:0]     cmd_data_o;
    logic              cmd_last_o;
    logic [N-1:0]      cmd_v_o, cmd_ready;
    logic [CW-1:0]     outstanding_o;
    logic              unexpected_cmd_o;

    bp_io_lce_req_arb #(
        .num_req_p(N),
        .header_width_p(HW),
        .data_width_p(DW),
        .max_outstanding_p(MAXO)
    ) dut (
        .clk_i(clk),
        .reset_n_i(rst_n),
        .req_header_i(req_header),
        .req_data_i(req_data),
        .req_v_i(req_v),
        .req_last_i(req_last),
        .req_ready_and_o(req_ready_and_o),
        .lce_req_header_o(lce_req_header_o),
        .lce_req_data_o(lce_req_data_o),
        .lce_req_v_o(lce_req_v_o),
        .lce_req_last_o(lce_req_last_o),
        .lce_req_ready_and_i(lce_req_ready),
        .lce_cmd_header_i(lce_cmd_header),
        .lce_cmd_data_i(lce_cmd_data),
        .lce_cmd_v_i(lce_cmd_v),
        .lce_cmd_last_i(lce_cmd_last),
        .lce_cmd_ready_and_o(lce_cmd_ready_and_o),
        .cmd_header_o(cmd_header_o),
        .cmd_data_o(cmd_data_o),
        .cmd_last_o(cmd_last_o),
        .cmd_v_o(cmd_v_o),
        .cmd_ready_and_i(cmd_ready),
        .outstanding_o(outstanding_o),
        .unexpected_cmd_o(unexpected_cmd_o)
    );

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: tags outstanding in issue order, round-robin start,
    // burst lock and sticky error flag.
    int q[$];
    int rr     = 0;
    bit locked = 0;
    int lock_g = 0;
    bit flag_m = 0;

    // Stimulus bookkeeping: beats left in each requester burst / command burst
    int rem[N];
    int crem = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare every output against the model, then advance the model by the
    // transfers that happen at the coming clock edge.
    task automatic settle();
        bit gv;
        int g;
        int h;
        bit empty_before;
        logic [63:0] exp_rdy, exp_cv, exp_cr;
        #3;
        gv = 0; g = 0; h = 0;
        empty_before = (q.size() == 0);
        if (!rst_n) begin
            chk("rst_lce_req_v", 64'(lce_req_v_o), 0);
            chk("rst_req_ready", 64'(req_ready_and_o), 0);
            chk("rst_cmd_v", 64'(cmd_v_o), 0);
            chk("rst_lce_cmd_ready", 64'(lce_cmd_ready_and_o), 0);
            chk("rst_outstanding", 64'(outstanding_o), 0);
            chk("rst_unexpected", 64'(unexpected_cmd_o), 0);
            q.delete();
            rr = 0; locked = 0; lock_g = 0; flag_m = 0; crem = 0;
            for (int i = 0; i < N; i++) rem[i] = 0;
        end else begin
            if (locked) begin
                g = lock_g; gv = req_v[g];
            end else if (q.size() < MAXO) begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (rr + k) % N;
                    if (!gv && req_v[c]) begin gv = 1; g = c; end
                end
            end
            exp_rdy = (gv && lce_req_ready) ? (64'(1) << g) : 64'(0);
            chk("lce_req_v", 64'(lce_req_v_o), 64'(gv));
            chk("req_ready", 64'(req_ready_and_o), exp_rdy);
            if (gv) begin
                chk("lce_req_header", 64'(lce_req_header_o), 64'(req_header[g*HW +: HW]));
                chk("lce_req_data", 64'(lce_req_data_o), 64'(req_data[g*DW +: DW]));
                chk("lce_req_last", 64'(lce_req_last_o), 64'(req_last[g]));
            end
            if (!empty_before) begin
                h = q[0];
                exp_cv = lce_cmd_v ? (64'(1) << h) : 64'(0);
                exp_cr = 64'(cmd_ready[h]);
            end else begin
                exp_cv = 0; exp_cr = 0;
            end
            chk("cmd_v", 64'(cmd_v_o), exp_cv);
            chk("lce_cmd_ready", 64'(lce_cmd_ready_and_o), exp_cr);
            chk("cmd_bcast", {31'd0, cmd_last_o, cmd_header_o, cmd_data_o},
                {31'd0, lce_cmd_last, lce_cmd_header, lce_cmd_data});
            chk("outstanding", 64'(outstanding_o), 64'(q.size()));
            chk("unexpected", 64'(unexpected_cmd_o), 64'(flag_m));

            if (gv && lce_req_ready) begin
                if (!locked) q.push_back(g);
                if (req_last[g]) begin
                    locked = 0; rr = (g + 1) % N;
                end else begin
                    locked = 1; lock_g = g;
                end
                if (rem[g] > 0) rem[g]--;
            end
            if (!empty_before && lce_cmd_v && cmd_ready[h]) begin
                if (crem > 0) crem--;
                if (lce_cmd_last) void'(q.pop_front());
            end
            if (lce_cmd_v && empty_before) flag_m = 1;
        end
    endtask

    task automatic quiet();
        rst_n = 1; req_v = '0; req_last = '0; lce_req_ready = 1;
        lce_cmd_v = 0; lce_cmd_last = 0; cmd_ready = '1;
    endtask

    task automatic do_reset();
        quiet();
        rst_n = 0;
        settle();
        tick();
        rst_n = 1;
    endtask

    task automatic gen(input int cmd_rate, input bit allow_err);
        for (int i = 0; i < N; i++) begin
            if (rem[i] == 0 && $urandom_range(0, 3) == 0) rem[i] = $urandom_range(1, 4);
            req_v[i]    = (rem[i] != 0) && ($urandom_range(0, 7) != 0);
            req_last[i] = (rem[i] == 1);
            req_header[i*HW +: HW] = HW'($urandom);
            req_data[i*DW +: DW]   = DW'($urandom);
        end
        lce_req_ready = ($urandom_range(0, 3) != 0);
        if (crem == 0 && (q.size() > 0 || allow_err) && $urandom_range(0, cmd_rate) == 0)
            crem = $urandom_range(1, 3);
        lce_cmd_v      = (crem != 0) && ($urandom_range(0, 5) != 0);
        lce_cmd_last   = (crem == 1);
        lce_cmd_header = HW'($urandom);
        lce_cmd_data   = DW'($urandom);
        cmd_ready      = N'($urandom_range(0, (1 << N) - 1)) | N'($urandom_range(0, 1) ? '1 : '0);
        rst_n          = ($urandom_range(0, 199) != 0);
    endtask

    initial begin
        req_header = '0; req_data = '0; lce_cmd_header = '0; lce_cmd_data = '0;
        quiet();
        rst_n = 0;
        settle();
        chk("reset_outstanding_lit", 64'(outstanding_o), 0);
        tick();
        rst_n = 1;

        // Single-beat requests from both requesters until credits run out
        req_v = 2'b11; req_last = 2'b11;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk("tp1_grant_lit", 64'(req_ready_and_o), (k % 2 == 0) ? 64'h1 : 64'h2);
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            settle();
            chk("tp1_stall_lit", 64'(lce_req_v_o), 0);
            chk("tp1_count_lit", 64'(outstanding_o), 4);
            tick();
        end
        lce_cmd_v = 1; lce_cmd_last = 1;
        settle();
        chk("tp1_route_lit", 64'(cmd_v_o), 64'h1);
        tick();
        lce_cmd_v = 0;
        settle();
        chk("tp1_regrant_lit", 64'(req_ready_and_o), 64'h1);
        chk("tp1_count3_lit", 64'(outstanding_o), 3);
        tick();

        // Burst lock: requester 0 sends 4 beats while requester 1 waits
        do_reset();
        req_v = 2'b11;
        for (int b = 0; b < 4; b++) begin
            req_last = {1'b1, (b == 3)};
            settle();
            chk("tp2_lock_lit", 64'(req_ready_and_o), 64'h1);
            chk("tp2_count_lit", 64'(outstanding_o), (b == 0) ? 64'd0 : 64'd1);
            tick();
        end
        settle();
        chk("tp2_next_lit", 64'(req_ready_and_o), 64'h2);
        chk("tp2_count1_lit", 64'(outstanding_o), 1);
        tick();

        // In-order routing: requests 1,0,1 then three 2-beat commands
        do_reset();
        req_last = 2'b11;
        req_v = 2'b10; settle(); tick();
        req_v = 2'b01; settle(); tick();
        req_v = 2'b10; settle(); tick();
        req_v = 2'b00;
        for (int c = 0; c < 3; c++) begin
            for (int b = 0; b < 2; b++) begin
                lce_cmd_v = 1; lce_cmd_last = (b == 1);
                settle();
                chk("tp3_route_lit", 64'(cmd_v_o), (c == 1) ? 64'h1 : 64'h2);
                chk("tp3_count_lit", 64'(outstanding_o), 64'(3 - c));
                tick();
            end
        end
        lce_cmd_v = 0;
        settle();
        chk("tp3_drain_lit", 64'(outstanding_o), 0);
        tick();

        // Simultaneous push and pop at count 2
        req_v = 2'b01; settle(); tick();
        req_v = 2'b10; settle(); tick();
        req_v = 2'b01; lce_cmd_v = 1; lce_cmd_last = 1;
        settle();
        chk("tp4_pop_lit", 64'(cmd_v_o), 64'h1);
        tick();
        req_v = 2'b00;
        settle();
        chk("tp4_count_lit", 64'(outstanding_o), 2);
        chk("tp4_order1_lit", 64'(cmd_v_o), 64'h2);
        tick();
        settle();
        chk("tp4_order0_lit", 64'(cmd_v_o), 64'h1);
        tick();
        lce_cmd_v = 0;

        // Backpressure on both sides
        do_reset();
        req_v = 2'b01; req_last = 2'b11; settle(); tick();
        req_v = 2'b00; lce_cmd_v = 1; lce_cmd_last = 1; cmd_ready = 2'b10;
        settle();
        chk("tp5_cmd_hold_lit", 64'(lce_cmd_ready_and_o), 0);
        tick();
        lce_cmd_v = 0; cmd_ready = 2'b11;
        req_v = 2'b10; lce_req_ready = 0; req_header[HW +: HW] = 16'hBEEF;
        for (int k = 0; k < 2; k++) begin
            settle();
            chk("tp5_count_lit", 64'(outstanding_o), 1);
            chk("tp5_hold_v_lit", 64'(lce_req_v_o), 1);
            chk("tp5_hold_hdr_lit", 64'(lce_req_header_o), 64'hBEEF);
            tick();
        end

        // Unexpected command, then reset in the middle of a burst
        do_reset();
        lce_cmd_v = 1; lce_cmd_last = 1;
        settle();
        chk("tp6_noready_lit", 64'(lce_cmd_ready_and_o), 0);
        tick();
        lce_cmd_v = 0;
        req_v = 2'b01; req_last = 2'b00;
        settle();
        chk("tp6_flag_lit", 64'(unexpected_cmd_o), 1);
        tick();
        rst_n = 0;
        settle();
        chk("tp6_rst_v_lit", 64'(lce_req_v_o), 0);
        tick();
        rst_n = 1; req_v = 2'b00;
        settle();
        chk("tp6_flag_clr_lit", 64'(unexpected_cmd_o), 0);
        chk("tp6_count_clr_lit", 64'(outstanding_o), 0);
        tick();

        // Randomized traffic: balanced, credit-starved, then with stray commands
        do_reset();
        for (int n = 0; n < 1500; n++) begin gen(2, 0);  settle(); tick(); end
        for (int n = 0; n < 1500; n++) begin gen(12, 0); settle(); tick(); end
        for (int n = 0; n < 1500; n++) begin gen(3, 1);  settle(); tick(); end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
